// File: rtl/hi_lo_pkg.sv
// hi_lo_pkg: operation and state encodings for the HI/LO unit
package hi_lo_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_WR   = 3'b001,
    OP_MADD = 3'b010,
    OP_MSUB = 3'b011,
    OP_MTHI = 3'b100,
    OP_MTLO = 3'b101,
    OP_MFHI = 3'b110,
    OP_MFLO = 3'b111
  } op_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;
endpackage

// File: rtl/hi_lo_acc_stage.sv
// hi_lo_acc_stage: captures an accumulate operand and produces the next {HI,LO} one edge later
module hi_lo_acc_stage
  import hi_lo_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  op_e          op_i,
  input  logic [W-1:0] product_i,
  input  logic [W-1:0] hilo_i,
  output logic         pending_o,
  output logic [W-1:0] hilo_nxt_o
);
  state_e       state_q, state_d;
  op_e          acc_op_q;
  logic [W-1:0] acc_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_op_q   <= OP_NOP;
      acc_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        acc_op_q   <= op_i;
        acc_data_q <= product_i;
      end
    end
  end
  always_comb begin
    state_d    = (state_q == ST_IDLE && start_i) ? ST_ACC : ST_IDLE;
    pending_o  = state_q == ST_ACC;
    hilo_nxt_o = (acc_op_q == OP_MSUB) ? hilo_i - acc_data_q : hilo_i + acc_data_q;
  end
endmodule

// File: rtl/hi_lo_unit.sv
// hi_lo_unit: MIPS HI/LO register unit with MULT write, MADD/MSUB accumulate, moves and reads
module hi_lo_unit
  import hi_lo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                OpValid,
  input  logic [2:0]          Op,
  input  logic [2*DATA_W-1:0] Product,
  input  logic [DATA_W-1:0]   WriteData,
  output logic                Stall,
  output logic [DATA_W-1:0]   ReadData,
  output logic                ReadValid,
  output logic [DATA_W-1:0]   HiOut,
  output logic [DATA_W-1:0]   LoOut
);
  op_e                 op;
  logic                req, acc, start, pending;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, rd_q, rd_d;
  logic                rv_q, rv_d;
  logic [2*DATA_W-1:0] acc_nxt;
  assign op    = op_e'(Op);
  assign req   = OpValid && op != OP_NOP;
  assign Stall = req && pending;
  assign acc   = req && !pending;
  assign start = acc && (op == OP_MADD || op == OP_MSUB);
  hi_lo_acc_stage #(.W(2*DATA_W)) u_acc (
    .clk       (Clk),
    .rst       (Rst),
    .start_i   (start),
    .op_i      (op),
    .product_i (Product),
    .hilo_i    ({hi_q, lo_q}),
    .pending_o (pending),
    .hilo_nxt_o(acc_nxt)
  );
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    rd_d = rd_q;
    rv_d = 1'b0;
    if (pending) {hi_d, lo_d} = acc_nxt;
    else if (acc && op == OP_WR) {hi_d, lo_d} = Product;
    else if (acc && op == OP_MTHI) hi_d = WriteData;
    else if (acc && op == OP_MTLO) lo_d = WriteData;
    else if (acc && (op == OP_MFHI || op == OP_MFLO)) begin
      rd_d = (op == OP_MFHI) ? hi_q : lo_q;
      rv_d = 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q <= '0;
      lo_q <= '0;
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      rd_q <= rd_d;
      rv_q <= rv_d;
    end
  end
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;
  assign ReadData  = rd_q;
  assign ReadValid = rv_q;
endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit: directed and random checks of hi_lo_unit against an arithmetic reference model
module tb_hi_lo_unit;
  logic        Clk = 0, Rst = 0, OpValid = 0, Stall, ReadValid;
  logic [2:0]  Op = 0;
  logic [63:0] Product = 0;
  logic [31:0] WriteData = 0, ReadData, HiOut, LoOut;
  int errs = 0, checks = 0;
  logic [63:0] m_hilo = 0, m_ad = 0;
  logic        m_pend = 0, m_sub = 0, m_rv = 0;
  logic [31:0] m_rd = 0;

  hi_lo_unit #(.DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .OpValid(OpValid), .Op(Op), .Product(Product),
    .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData),
    .ReadValid(ReadValid), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [2:0] op, input logic [63:0] p,
                     input logic [31:0] wd, output bit acc);
    Rst = r; OpValid = v; Op = op; Product = p; WriteData = wd;
    #1;
    chk("stall", Stall, v && op != 0 && m_pend);
    @(posedge Clk);
    acc = 0;
    if (r) begin
      m_hilo = 0; m_ad = 0; m_pend = 0; m_sub = 0; m_rv = 0; m_rd = 0;
    end else begin
      m_rv = 0;
      if (m_pend) begin
        m_hilo = m_sub ? m_hilo - m_ad : m_hilo + m_ad;
        m_pend = 0;
      end else if (v && op != 0) begin
        acc = 1;
        case (op)
          3'd1: m_hilo = p;
          3'd2, 3'd3: begin m_pend = 1; m_sub = op[0]; m_ad = p; end
          3'd4: m_hilo[63:32] = wd;
          3'd5: m_hilo[31:0] = wd;
          3'd6: begin m_rd = m_hilo[63:32]; m_rv = 1; end
          default: begin m_rd = m_hilo[31:0]; m_rv = 1; end
        endcase
      end
    end
    @(negedge Clk);
    chk("hi", HiOut, m_hilo[63:32]);
    chk("lo", LoOut, m_hilo[31:0]);
    chk("read_valid", ReadValid, m_rv);
    chk("read_data", ReadData, m_rd);
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] p, input logic [31:0] wd,
                       output int stalls);
    bit a = 0;
    stalls = 0;
    for (int i = 0; i < 4 && !a; i++) begin
      cyc(0, 1, op, p, wd, a);
      if (!a) stalls++;
    end
    chk("accept_bound", a, 1);
  endtask

  task automatic idle();
    bit a;
    cyc(0, 0, 3'd0, 64'h0, 32'h0, a);
  endtask

  initial begin
    bit a;
    int s;
    @(negedge Clk);
    cyc(1, 0, 3'd0, 64'h0, 32'h0, a);
    chk("rst_hi", HiOut, 0);
    chk("rst_lo", LoOut, 0);
    issue(3'd6, 64'h0, 32'h0, s);
    chk("rst_mfhi_valid", ReadValid, 1);
    chk("rst_mfhi_data", ReadData, 32'h0);
    idle();
    chk("rv_pulse_end", ReadValid, 0);

    issue(3'd1, 64'h00000001_FFFFFFFE, 32'h0, s);
    chk("wr_hi", HiOut, 32'h00000001);
    chk("wr_lo", LoOut, 32'hFFFFFFFE);
    issue(3'd7, 64'h0, 32'h0, s);
    chk("mflo_data", ReadData, 32'hFFFFFFFE);

    issue(3'd1, 64'h00000000_FFFFFFFF, 32'h0, s);
    issue(3'd2, 64'h1, 32'h0, s);
    chk("madd_no_stall", s, 0);
    issue(3'd6, 64'h0, 32'h0, s);
    chk("madd_stall_cycles", s, 1);
    chk("madd_hi", HiOut, 32'h00000001);
    chk("madd_lo", LoOut, 32'h00000000);
    chk("madd_read", ReadData, 32'h00000001);

    issue(3'd1, 64'h0, 32'h0, s);
    issue(3'd3, 64'h1, 32'h0, s);
    idle();
    chk("msub_hi", HiOut, 32'hFFFFFFFF);
    chk("msub_lo", LoOut, 32'hFFFFFFFF);

    issue(3'd4, 64'h0, 32'hDEADBEEF, s);
    chk("mthi_lo_kept", LoOut, 32'hFFFFFFFF);
    issue(3'd5, 64'h0, 32'h12345678, s);
    chk("mtlo_hi", HiOut, 32'hDEADBEEF);
    chk("mtlo_lo", LoOut, 32'h12345678);

    issue(3'd2, 64'h5, 32'h0, s);
    cyc(1, 0, 3'd0, 64'h0, 32'h0, a);
    chk("rst_acc_hi", HiOut, 0);
    chk("rst_acc_lo", LoOut, 0);
    issue(3'd6, 64'h0, 32'h0, s);
    chk("rst_acc_no_stall", s, 0);
    idle();
    chk("rst_acc_no_late_write", {HiOut, LoOut}, 64'h0);

    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 9);
      if (k == 0) cyc($urandom_range(0, 5) == 0, 0, 3'd0, 64'h0, 32'h0, a);
      else if (k == 1) cyc(0, 1, 3'd0, {$urandom, $urandom}, $urandom, a);
      else issue(3'($urandom_range(1, 7)), {$urandom, $urandom}, $urandom, s);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
